l2_assoc_lookup_return: RTL and testbench

// - Parametrised fully-associative L2 lookup/return engine between the L1 refill path and main memory.
// - Accepts one L1 miss request at a time and compares its line address against all valid L2 tags.
// - On hit: returns the stored line to L1.
// - On miss: fetches the line from memory, installs it in a victim line, then returns it to L1.
// - Victim choice: first invalid line if any, else pseudo-random.

---
 rtl/l2_assoc_lookup_return_if.sv | 47 ++++
 rtl/l2_assoc_lookup_return.sv | 216 +++++++++++++++++++++
 tb/tb_l2_assoc_lookup_return.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_assoc_lookup_return_if.sv
// -----------------------------------------------------------------------------
// l2_assoc_lookup_return_if
//
// Purpose: bundles the L1-facing request/response channel and the
// memory-facing fetch channel of the L2 lookup/return engine.
//
// Signals (direction as seen from the L2 engine, modport "slave"):
//   req_to_l2  in   L1 request valid
//   addr       in   requested line address, sampled on accept
//   l2_ready   out  1 = request accepted this cycle if req_to_l2=1
//   flush      in   invalidate all lines (IDLE only)
//   ack_to_l1  out  one-cycle response strobe
//   addr_tag   out  tag of the returned line, valid with ack_to_l1
//   data       out  returned line, valid with ack_to_l1
//   mem_req    out  memory fetch request, held until mem_ack
//   mem_addr   out  fetch address, stable while mem_req=1
//   mem_ack    in   memory data valid strobe
//   mem_data   in   fetched line, sampled when mem_ack=1
//
// The "master" modport is the environment view (L1 refill path + memory).
// -----------------------------------------------------------------------------
interface l2_assoc_lookup_return_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 256
);
  logic              req_to_l2;
  logic [ADDR_W-1:0] addr;
  logic              l2_ready;
  logic              flush;
  logic              ack_to_l1;
  logic [ADDR_W-1:0] addr_tag;
  logic [DATA_W-1:0] data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  modport slave (
    input  req_to_l2, addr, flush, mem_ack, mem_data,
    output l2_ready, ack_to_l1, addr_tag, data, mem_req, mem_addr
  );

  modport master (
    output req_to_l2, addr, flush, mem_ack, mem_data,
    input  l2_ready, ack_to_l1, addr_tag, data, mem_req, mem_addr
  );
endinterface

// File: rtl/l2_assoc_lookup_return.sv
// -----------------------------------------------------------------------------
// l2_assoc_lookup_return
//
// Purpose: fully-associative L2 lookup/return engine sitting between the L1
// refill path and main memory. One L1 miss is handled at a time: its line
// address is compared against every valid tag; a hit returns the stored
// line, a miss fetches the line from memory, installs it in a victim line
// and then returns it.
//
// Victim choice: lowest-index invalid line; when every line is valid the
// low log2(NUM_LINES) bits of a free-running 16-bit LFSR pick the line.
//
// Ports:
//   clk       in   clock, all state changes on posedge
//   rst       in   synchronous reset, active-low
//   bus       slave modport of l2_assoc_lookup_return_if (L1 + memory side)
//   hit_cnt   out  [31:0] saturating hit counter   (L2_STATS_EN only)
//   miss_cnt  out  [31:0] saturating miss counter  (L2_STATS_EN only)
//
// Configuration macro:
//   L2_STATS_EN  when defined, adds the hit_cnt/miss_cnt outputs. Both
//                counters saturate and are cleared by reset and by flush.
//
// While rst=0 every handshake output and the returned tag/data read as zero.
// -----------------------------------------------------------------------------
module l2_assoc_lookup_return #(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 256,
  parameter int          NUM_LINES = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst,
  l2_assoc_lookup_return_if.slave     bus
`ifdef L2_STATS_EN
  ,
  output logic [31:0]                 hit_cnt,
  output logic [31:0]                 miss_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_HIT,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_FILL_RESP
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;          // latched request address
  logic [NUM_LINES-1:0] valid_q;
  logic [ADDR_W-1:0]   tag_q  [NUM_LINES];
  logic [DATA_W-1:0]   data_q [NUM_LINES];
  logic [IDX_W-1:0]    victim_q;        // victim frozen in the LOOKUP cycle
  logic [ADDR_W-1:0]   resp_tag_q;      // addr_tag holding register
  logic [DATA_W-1:0]   resp_data_q;     // data holding register
  logic [15:0]         lfsr_q;
  logic [15:0]         lfsr_next;

  // ---------------------------------------------------------------------------
  // Decoded control
  // ---------------------------------------------------------------------------
  logic             in_idle;
  logic             in_miss;
  logic             flush_now;
  logic             accept;
  logic             fill;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             inv_found;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] victim;

  assign in_idle   = (state_q == S_IDLE);
  assign in_miss   = (state_q == S_MISS_REQ) || (state_q == S_MISS_WAIT);
  // flush wins over a simultaneous request; it is dropped outside IDLE.
  assign flush_now = in_idle && bus.flush;
  assign accept    = in_idle && !bus.flush && bus.req_to_l2;
  // mem_ack only means something while a fetch is outstanding.
  assign fill      = in_miss && bus.mem_ack;

  // Fibonacci LFSR, taps 16,14,13,11. A non-zero seed keeps it non-zero.
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Tag compare across all lines; valid bits gate every match so addr=0 is
  // an ordinary tag. Tags are unique, so at most one line can match.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment would infer a latch.
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == addr_q)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Lowest-index invalid line: scanning downward leaves the lowest one.
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
  end

  assign victim = inv_found ? inv_idx : lfsr_q[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (accept)       state_d = S_LOOKUP;
      S_LOOKUP:    state_d = hit_any ? S_HIT : S_MISS_REQ;
      S_HIT:       state_d = S_IDLE;
      // mem_ack may already arrive in the first request cycle.
      S_MISS_REQ:  state_d = bus.mem_ack ? S_FILL_RESP : S_MISS_WAIT;
      S_MISS_WAIT: if (bus.mem_ack)  state_d = S_FILL_RESP;
      S_FILL_RESP: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      valid_q     <= '0;
      victim_q    <= '0;
      resp_tag_q  <= '0;
      resp_data_q <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_next;

      if (accept) addr_q <= bus.addr;
      if (flush_now) valid_q <= '0;
      if (state_q == S_LOOKUP) victim_q <= victim;

      if ((state_q == S_LOOKUP) && hit_any) begin
        resp_tag_q  <= addr_q;
        resp_data_q <= data_q[hit_idx];
      end

      if (fill) begin
        valid_q[victim_q] <= 1'b1;
        resp_tag_q        <= addr_q;
        resp_data_q       <= bus.mem_data;
      end
    end
  end

  // Tag/data storage. NOTE: the arrays are deliberately not reset; the valid
  // bits alone decide whether a line's contents mean anything.
  always_ff @(posedge clk) begin
    if (rst && fill) begin
      tag_q[victim_q]  <= addr_q;
      data_q[victim_q] <= bus.mem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: forced low while reset is asserted, even before the reset edge.
  // ---------------------------------------------------------------------------
  assign bus.l2_ready  = rst && in_idle;
  assign bus.ack_to_l1 = rst && ((state_q == S_HIT) || (state_q == S_FILL_RESP));
  assign bus.mem_req   = rst && in_miss;
  assign bus.mem_addr  = rst ? addr_q      : '0;
  assign bus.addr_tag  = rst ? resp_tag_q  : '0;
  assign bus.data      = rst ? resp_data_q : '0;

`ifdef L2_STATS_EN
  // ---------------------------------------------------------------------------
  // Optional saturating hit/miss statistics, counted on leaving LOOKUP.
  // ---------------------------------------------------------------------------
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || flush_now) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit_any) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l2_assoc_lookup_return.sv
// -----------------------------------------------------------------------------
// tb_l2_assoc_lookup_return
//
// Directed bench for l2_assoc_lookup_return. A transaction-level cache model
// (tag/valid/data arrays, lowest-invalid-else-LFSR victim rule, free-running
// reference LFSR) sets the expected output values for each cycle; a single
// compare process checks them on every falling edge. Literal checks pin the
// model on the hand-computed scenarios. Define L2_STATS_EN to also cover the
// statistics counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l2_assoc_lookup_return;

  localparam int          ADDR_W    = 16;
  localparam int          DATA_W    = 256;
  localparam int          NUM_LINES = 32;
  localparam int          IDX_W     = 5;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_assoc_lookup_return_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef L2_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  l2_assoc_lookup_return #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LINES(NUM_LINES), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef L2_STATS_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic              m_valid [NUM_LINES];
  logic [ADDR_W-1:0] m_tag   [NUM_LINES];
  logic [DATA_W-1:0] m_data  [NUM_LINES];
  logic [15:0]       m_lfsr;
  int                m_hit  = 0;
  int                m_miss = 0;
  int                last_victim = 0;
  int                salt = 0;

  // Reference LFSR: seed on reset, one step every clock with rst=1.
  always @(posedge clk) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic int victim_pick();
    for (int i = 0; i < NUM_LINES; i++)
      if (!m_valid[i]) return i;
    return int'(m_lfsr[IDX_W-1:0]);
  endfunction

  function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a, input int s);
    return {32'(s), {7{a, 16'hC0DE}}};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    m_hit  = 0;
    m_miss = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Expected outputs for the current cycle, checked on every falling edge
  // ---------------------------------------------------------------------------
  logic              chk_en       = 1'b0;
  logic              exp_ready    = 1'b0;
  logic              exp_ack      = 1'b0;
  logic              exp_mem_req  = 1'b0;
  logic [ADDR_W-1:0] exp_tag      = '0;
  logic [DATA_W-1:0] exp_data     = '0;
  logic [ADDR_W-1:0] exp_mem_addr = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("l2_ready",  DATA_W'(bus.l2_ready),  DATA_W'(exp_ready));
      check("ack_to_l1", DATA_W'(bus.ack_to_l1), DATA_W'(exp_ack));
      check("mem_req",   DATA_W'(bus.mem_req),   DATA_W'(exp_mem_req));
      check("addr_tag",  DATA_W'(bus.addr_tag),  DATA_W'(exp_tag));
      check("data",      bus.data,               exp_data);
      if (exp_mem_req)
        check("mem_addr", DATA_W'(bus.mem_addr), DATA_W'(exp_mem_addr));
      else if (!rst)
        check("mem_addr_rst", DATA_W'(bus.mem_addr), '0);
`ifdef L2_STATS_EN
      check("hit_cnt",  DATA_W'(hit_cnt),  DATA_W'(m_hit));
      check("miss_cnt", DATA_W'(miss_cnt), DATA_W'(m_miss));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the rising edge
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_ready   = 1'b1;
    exp_ack     = 1'b0;
    exp_mem_req = 1'b0;
  endtask

  // One L1 request. noise=1 drives a second request, flush and a stray
  // mem_ack while the engine is busy; all of them must be ignored.
  task automatic txn(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] fill,
                     input int delay, input bit noise,
                     output bit missed, output logic [DATA_W-1:0] got);
    bit hit;
    int idx;
    // IDLE cycle, accepted at the next edge
    cyc();
    bus.req_to_l2 = 1'b1;
    bus.addr      = a;
    set_idle();
    // LOOKUP cycle: the victim is decided from the state seen now
    cyc();
    bus.req_to_l2 = noise;
    bus.addr      = noise ? ~a : a;
    bus.flush     = noise;
    bus.mem_ack   = noise;
    exp_ready     = 1'b0;
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < NUM_LINES; i++)
      if (m_valid[i] && m_tag[i] == a) begin hit = 1'b1; idx = i; end
    if (!hit) idx = victim_pick();
    // request + 2
    cyc();
    bus.flush   = 1'b0;
    bus.mem_ack = 1'b0;
    if (hit) begin
      m_hit++;
      exp_ack  = 1'b1;
      exp_tag  = a;
      exp_data = m_data[idx];
      @(negedge clk);
      missed = bus.mem_req;
      got    = bus.data;
    end else begin
      m_miss++;
      exp_mem_req  = 1'b1;
      exp_mem_addr = a;
      if (delay == 0) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = fill;
      end
      @(negedge clk);
      missed = bus.mem_req;
      for (int d = 1; d <= delay; d++) begin
        cyc();
        if (d == delay) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = fill;
        end
      end
      // response cycle; mem_data changes to prove it was captured earlier
      cyc();
      bus.mem_ack  = 1'b0;
      bus.mem_data = ~fill;
      exp_mem_req  = 1'b0;
      exp_ack      = 1'b1;
      exp_tag      = a;
      exp_data     = fill;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a;
      m_data[idx]  = fill;
      last_victim  = idx;
      @(negedge clk);
      got = bus.data;
    end
    cyc();
    bus.req_to_l2 = 1'b0;
    set_idle();
  endtask

  // Two-cycle reset with mem_ack asserted throughout and just after.
  task automatic do_reset();
    cyc();
    rst          = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.mem_data = {8{32'hDEAD_BEEF}};
    exp_ready    = 1'b0;
    exp_ack      = 1'b0;
    exp_mem_req  = 1'b0;
    exp_tag      = '0;
    exp_data     = '0;
    cyc();
    model_clear();
    cyc();
    rst = 1'b1;
    set_idle();
    cyc();
    bus.mem_ack = 1'b0;
    set_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit                missed;
    logic [DATA_W-1:0] got;
    int                miss_seen;
    int                v;

    bus.req_to_l2 = 1'b0;
    bus.addr      = '0;
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_data  = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end

    // Reset state: all outputs zero while rst=0, l2_ready=1 once released
    repeat (3) cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b1;
    set_idle();
    cyc();

    // Miss on addr 0, then a hit on it with busy-time noise
    txn(16'h0000, 256'h1, 2, 1'b0, missed, got);
    check("first_req_missed", DATA_W'(missed), DATA_W'(1));
    check("first_fill_data",  got, 256'h1);
    txn(16'h0000, 256'h0, 0, 1'b1, missed, got);
    check("repeat_req_hit",   DATA_W'(missed), DATA_W'(0));
    check("repeat_hit_data",  got, 256'h1);

    // Stray mem_ack in IDLE is ignored
    cyc();
    bus.mem_ack  = 1'b1;
    bus.mem_data = {8{32'h5555_AAAA}};
    set_idle();
    cyc();
    bus.mem_ack = 1'b0;

    // flush beats a simultaneous request
    cyc();
    bus.flush     = 1'b1;
    bus.req_to_l2 = 1'b1;
    bus.addr      = 16'h0100;
    set_idle();
    cyc();
    bus.flush     = 1'b0;
    bus.req_to_l2 = 1'b0;
    model_clear();
    set_idle();
    txn(16'h0100, mk_data(16'h0100, salt++), 1, 1'b0, missed, got);
    check("after_flush_miss", DATA_W'(missed), DATA_W'(1));

    // Fill the remaining 31 lines; mem_ack delays 0..2 include same-cycle ack
    miss_seen = 0;
    for (int i = 1; i < NUM_LINES; i++) begin
      txn(ADDR_W'(16'h0100 + i), mk_data(ADDR_W'(16'h0100 + i), salt++), i % 3, 1'b0, missed, got);
      miss_seen += int'(missed);
    end
    check("fill_all_missed", DATA_W'(miss_seen), DATA_W'(31));

    // Full cache: 0x0200 replaces exactly the LFSR-selected line
    txn(16'h0200, mk_data(16'h0200, salt++), 2, 1'b0, missed, got);
    check("full_cache_miss", DATA_W'(missed), DATA_W'(1));
    v = last_victim;
    miss_seen = 0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (i != v) begin
        txn(ADDR_W'(16'h0100 + i), '0, 0, (i % 7) == 0, missed, got);
        miss_seen += int'(missed);
      end
    end
    check("old_lines_still_hit", DATA_W'(miss_seen), DATA_W'(0));
    txn(ADDR_W'(16'h0100 + v), mk_data(ADDR_W'(16'h0100 + v), salt++), 1, 1'b0, missed, got);
    check("evicted_line_misses", DATA_W'(missed), DATA_W'(1));

    // Reset during MISS_WAIT: the late mem_ack must not fill or respond
    cyc();
    bus.req_to_l2 = 1'b1;
    bus.addr      = 16'h0300;
    set_idle();
    cyc();
    bus.req_to_l2 = 1'b0;
    exp_ready     = 1'b0;
    cyc();
    m_miss++;
    exp_mem_req  = 1'b1;
    exp_mem_addr = 16'h0300;
    cyc();
    do_reset();
    cyc();
    txn(16'h0300, mk_data(16'h0300, salt++), 3, 1'b0, missed, got);
    check("no_fill_after_reset", DATA_W'(missed), DATA_W'(1));

`ifdef L2_STATS_EN
    // One miss then three hits from a clean reset
    do_reset();
    txn(16'h0ABC, mk_data(16'h0ABC, salt++), 1, 1'b0, missed, got);
    txn(16'h0ABC, '0, 0, 1'b0, missed, got);
    txn(16'h0ABC, '0, 0, 1'b1, missed, got);
    txn(16'h0ABC, '0, 0, 1'b0, missed, got);
    @(negedge clk);
    check("stats_hit_cnt",  DATA_W'(hit_cnt),  DATA_W'(3));
    check("stats_miss_cnt", DATA_W'(miss_cnt), DATA_W'(1));
`endif

    cyc();
    cyc();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
